// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between four requesters and the round-robin mux-select arbiter.
// The master drives requests and release; the arbiter (slave) drives select and grant.
interface mux_sel_arbiter_if;
    logic [3:0] i_req;
    logic       i_release;
    logic [1:0] o_sel;
    logic [3:0] o_grant;
    logic       o_busy;
    logic       o_timeout;

    modport master (
        output i_req, i_release,
        input  o_sel, o_grant, o_busy, o_timeout
    );

    modport slave (
        input  i_req, i_release,
        output o_sel, o_grant, o_busy, o_timeout
    );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner arbiter driving a 4:1 mux select and one-hot grant.
// A grant is held until release, request drop or MAX_HOLD cycles, then one idle cycle follows.
module mux_sel_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_sel_arbiter_if.slave bus
);

    localparam int             CNT_W     = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_ptr;
    logic [1:0]       r_sel;
    logic [3:0]       r_grant;
    logic             r_timeout;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0]       w_pick;
    logic             w_found;
    logic             w_norm_rel;
    logic             w_force_rel;

    // First requester found scanning upward from the priority pointer, wrapping 3 -> 0.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        for (int k = 0; k < 4; k++) begin
            if (!w_found && bus.i_req[r_ptr + 2'(k)]) begin
                w_found = 1'b1;
                w_pick  = r_ptr + 2'(k);
            end
        end
    end

    assign w_norm_rel  = bus.i_release || !bus.i_req[r_sel];
    assign w_force_rel = !w_norm_rel && (r_cnt == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_found) w_next_state = BUSY;
            BUSY:    if (w_norm_rel || w_force_rel) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Select, grant, pointer and hold counter; sel is deliberately kept across IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel     <= 2'b00;
            r_grant   <= 4'b0000;
            r_timeout <= 1'b0;
            r_ptr     <= 2'b00;
            r_cnt     <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_sel   <= w_pick;
                        r_grant <= 4'b0001 << w_pick;
                        r_cnt   <= '0;
                    end
                end
                BUSY: begin
                    if (w_norm_rel || w_force_rel) begin
                        r_grant   <= 4'b0000;
                        r_ptr     <= r_sel + 2'd1;
                        r_timeout <= w_force_rel;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_grant <= 4'b0000;
                end
            endcase
        end
    end

    always_comb begin
        bus.o_sel     = r_sel;
        bus.o_grant   = r_grant;
        bus.o_busy    = (r_state == BUSY);
        bus.o_timeout = r_timeout;
    end

endmodule
